// File: rtl/osc_cal_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the ring-oscillator calibration controller.
package osc_cal_pkg;

  localparam int NUM_CODES = 4;
  localparam int CODE_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    EVAL,
    DONE
  } state_e;

endpackage

// File: rtl/osc_edge_sync.sv
`timescale 1ns/1ps
// Brings the asynchronous oscillator phase into the clk domain and emits a
// one-cycle pulse for each rising edge seen after synchronization.
module osc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic osc_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= osc_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/osc_cal_ctrl.sv
`timescale 1ns/1ps
// Sweeps the oscillator control code, measures edge counts per code over a fixed
// window, and settles on the code whose count lies closest to the target.
module osc_cal_ctrl
  import osc_cal_pkg::*;
#(
  parameter int              CNT_W      = 12,
  parameter int              WINDOW_CYC = 256,
  parameter int              SETTLE_CYC = 16,
  parameter logic [CODE_W-1:0] CTRL_RST = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  target_cnt,
  input  logic [CNT_W-1:0]  tol,
  input  logic              osc_in,
  output logic [CODE_W-1:0] ctrl,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  best_cnt,
  output logic              cal_err
);

  localparam int MAX_CYC = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
  localparam int CYC_W   = $clog2(MAX_CYC + 1);
  localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(NUM_CODES - 1);

  state_e             state_q;
  logic [CYC_W-1:0]   cyc_q;
  logic [CODE_W-1:0]  code_q;
  logic [CNT_W-1:0]   edge_cnt_q;
  logic [CNT_W-1:0]   target_q;
  logic [CNT_W-1:0]   tol_q;
  logic [CODE_W-1:0]  best_code_q;
  logic [CNT_W:0]     best_diff_q;
  logic [CNT_W-1:0]   meas_best_q;
  logic [CODE_W-1:0]  ctrl_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   best_cnt_q;
  logic               cal_err_q;

  logic               edge_rise;
  logic [CNT_W:0]     diff_d;
  logic               take_d;
  logic [CODE_W-1:0]  best_code_d;
  logic [CNT_W:0]     best_diff_d;
  logic [CNT_W-1:0]   meas_best_d;

  osc_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .osc_i  (osc_in),
    .rise_o (edge_rise)
  );

  // Candidate best-code update; the last EVAL needs it combinationally so DONE
  // can publish the final choice on the same edge.
  always_comb begin
    if (edge_cnt_q >= target_q) diff_d = {1'b0, edge_cnt_q} - {1'b0, target_q};
    else                        diff_d = {1'b0, target_q} - {1'b0, edge_cnt_q};
    take_d      = (code_q == '0) || (diff_d < best_diff_q);
    best_code_d = take_d ? code_q     : best_code_q;
    best_diff_d = take_d ? diff_d     : best_diff_q;
    meas_best_d = take_d ? edge_cnt_q : meas_best_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      code_q      <= '0;
      edge_cnt_q  <= '0;
      target_q    <= '0;
      tol_q       <= '0;
      best_code_q <= '0;
      best_diff_q <= '0;
      meas_best_q <= '0;
      ctrl_q      <= CTRL_RST;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      best_cnt_q  <= '0;
      cal_err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            target_q   <= target_cnt;
            tol_q      <= tol;
            code_q     <= '0;
            ctrl_q     <= '0;
            busy_q     <= 1'b1;
            cyc_q      <= '0;
            edge_cnt_q <= '0;
            state_q    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
            cyc_q   <= '0;
            state_q <= MEASURE;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        MEASURE: begin
          // Saturate rather than wrap so a very fast oscillator still reads as far off.
          if (edge_rise && (edge_cnt_q != '1)) edge_cnt_q <= edge_cnt_q + CNT_W'(1);
          if (cyc_q == CYC_W'(WINDOW_CYC - 1)) begin
            cyc_q   <= '0;
            state_q <= EVAL;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        EVAL: begin
          best_code_q <= best_code_d;
          best_diff_q <= best_diff_d;
          meas_best_q <= meas_best_d;
          if (code_q == LAST_CODE) begin
            ctrl_q     <= best_code_d;
            best_cnt_q <= meas_best_d;
            cal_err_q  <= (best_diff_d > {1'b0, tol_q});
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            code_q     <= code_q + CODE_W'(1);
            ctrl_q     <= code_q + CODE_W'(1);
            edge_cnt_q <= '0;
            state_q    <= SETTLE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ctrl     = ctrl_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign best_cnt = best_cnt_q;
  assign cal_err  = cal_err_q;

endmodule
